// File: rtl/booth_mul_seq_pkg.sv
// Shared definitions for the Booth multiplier family: state encoding,
// radix-4 digit operations and width helpers.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Addend operation selected by one radix-4 Booth digit
    localparam logic [2:0] ZERO = 3'd0;
    localparam logic [2:0] P1   = 3'd1;
    localparam logic [2:0] P2   = 3'd2;
    localparam logic [2:0] M1   = 3'd3;
    localparam logic [2:0] M2   = 3'd4;

    // Booth iterations for a given operand width
    function automatic int iter_of(input int w);
        return w / 2 + 1;
    endfunction

    // Counter width able to hold 0..ITER
    function automatic int cnt_w_of(input int w);
        return $clog2(w / 2 + 2);
    endfunction

    // Map {b[i+1], b[i], b[i-1]} to the addend operation
    function automatic logic [2:0] booth_decode(input logic [2:0] digit);
        logic [2:0] op;
        case (digit)
            3'b001, 3'b010: op = P1;
            3'b011:         op = P2;
            3'b100:         op = M2;
            3'b101, 3'b110: op = M1;
            default:        op = ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_r4_select.sv
// Radix-4 Booth addend select: produces 0, +-M or +-2M at accumulator
// width from a 3-bit digit and the (WIDTH+2)-bit extended multiplicand.
module booth_r4_select
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       digit,
    input  logic [WIDTH+1:0] mext,
    output logic [WIDTH+2:0] addend
);

    logic [WIDTH+2:0] m1;
    logic [WIDTH+2:0] m2;

    // mext already carries two copies of its sign, so the left shift keeps it
    assign m1 = {mext[WIDTH+1], mext};
    assign m2 = {mext, 1'b0};

    // Pick the addend for this digit
    always_comb begin
        addend = '0;
        case (booth_decode(digit))
            P1:      addend = m1;
            P2:      addend = m2;
            M1:      addend = -m1;
            M2:      addend = -m2;
            default: addend = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, one digit per clock, signed or
// unsigned operands, start/busy/done handshake, registered 2*WIDTH product.
// Optional MUL_OVF_FLAG_EN adds an ovf output registered with prod.
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
`ifdef MUL_OVF_FLAG_EN
    ,
    output logic               ovf
`endif
);

    localparam int ITER = iter_of(WIDTH);
    localparam int CW   = cnt_w_of(WIDTH);
    localparam int AW   = WIDTH + 3;
    localparam int MW   = WIDTH + 2;

    state_t             state_q, state_d;
    logic [MW-1:0]      mcand_q, mcand_d;
    logic [MW-1:0]      mreg_q, mreg_d;
    logic               carry_q, carry_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [AW-1:0]      addend;
    logic [AW-1:0]      sum;
    logic [AW+MW-1:0]   pair_sh;
    logic               ext_m;

`ifdef MUL_OVF_FLAG_EN
    logic               sgn_q, sgn_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH:0]     hi_s;
    assign hi_s = pair_sh[2*WIDTH-1:WIDTH-1];
    assign ovf  = ovf_q;
`endif

    booth_r4_select #(.WIDTH(WIDTH)) u_sel (
        .digit  ({mreg_q[1:0], carry_q}),
        .mext   (mcand_q),
        .addend (addend)
    );

    // Add, then arithmetic-shift the whole {acc, mplier} pair right by 2
    assign sum     = acc_q + addend;
    assign pair_sh = $signed({sum, mreg_q}) >>> 2;
    assign ext_m   = is_signed & mplier[WIDTH-1];
    assign prod    = prod_q;

    // Next-state, datapath update and handshake outputs
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mreg_d  = mreg_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
`ifdef MUL_OVF_FLAG_EN
        sgn_d   = sgn_q;
        ovf_d   = ovf_q;
`endif
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done    = (state_q == DONE);
                state_d = IDLE;
                if (start) begin
                    mcand_d = {{2{is_signed & mcand[WIDTH-1]}}, mcand};
                    mreg_d  = {ext_m, ext_m, mplier};
                    carry_d = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef MUL_OVF_FLAG_EN
                    sgn_d   = is_signed;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                carry_d = mreg_q[1];
                acc_d   = pair_sh[AW+MW-1:MW];
                mreg_d  = pair_sh[MW-1:0];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    // Final digit: product is the low bits of the shifted pair
                    prod_d  = pair_sh[2*WIDTH-1:0];
`ifdef MUL_OVF_FLAG_EN
                    ovf_d   = sgn_q ? ~((&hi_s) | ~(|hi_s))
                                    : (|pair_sh[2*WIDTH-1:WIDTH]);
`endif
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mreg_q  <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
`ifdef MUL_OVF_FLAG_EN
            sgn_q   <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mreg_q  <= mreg_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
`ifdef MUL_OVF_FLAG_EN
            sgn_q   <= sgn_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: directed vector table, hand-written clear and
// back-to-back sequences, random 32-bit ops against a plain-arithmetic
// reference, and a WIDTH=4/8/16 random sweep.
module tb_booth_mul_seq;

    logic        clk, rst;
    logic        start, is_signed, busy, done;
    logic [31:0] mcand, mplier;
    logic [63:0] prod;
`ifdef MUL_OVF_FLAG_EN
    logic        ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic sweep_go = 1'b0;
    int   sweep_fin = 0;

    booth_mul_seq #(.WIDTH(32)) dut (
        .clock     (clk),
        .clear     (rst),
        .start     (start),
        .is_signed (is_signed),
        .mcand     (mcand),
        .mplier    (mplier),
        .busy      (busy),
        .done      (done),
        .prod      (prod)
`ifdef MUL_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic sg);
        logic [63:0] x, y;
        x = sg ? {{32{a[31]}}, a} : {32'd0, a};
        y = sg ? {{32{b[31]}}, b} : {32'd0, b};
        return x * y;
    endfunction

    function automatic logic ref_ovf(input logic [63:0] p, input logic sg);
        if (sg) return ($signed(p) < -64'sd2147483648) || ($signed(p) > 64'sd2147483647);
        return p > 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic cur_ovf();
`ifdef MUL_OVF_FLAG_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Called #1 after the accepting edge; counts cycles until done is seen
    task automatic wait_done(output int n, output int bc);
        logic [63:0] p0;
        logic chg;
        p0 = prod; chg = 1'b0; n = 1; bc = 0;
        while (!done && n < 100) begin
            if (busy) bc++;
            if (prod !== p0) chg = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        chk("prod_stable_in_run", 128'(chg), 128'(0));
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got no done, expected done within 100 cycles");
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                          output logic [63:0] p, output logic ov, output int lat, output int bc);
        @(negedge clk);
        mcand = a; mplier = b; is_signed = sg; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bc);
        p  = prod;
        ov = cur_ovf();
        chk("busy_in_done", 128'(busy), 128'(0));
        @(posedge clk); #1;
        chk("done_one_cycle", 128'(done), 128'(0));
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        logic [63:0] p;
        logic        ov;
    } vec_t;

    initial begin
        vec_t        vt[10];
        logic [31:0] cor[4];
        logic [63:0] p;
        logic        ov, seen;
        int          lat, bc, n;
        logic [31:0] a, b;
        logic        sg;

        vt[0] = '{32'hFFFF_FFF9, 32'd3,         1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
        vt[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1};
        vt[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 1'b0};
        vt[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b1};
        vt[4] = '{32'd5,         32'd6,         1'b1, 64'd30,                  1'b0};
        vt[5] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000, 1'b1};
        vt[6] = '{32'h8000_0000, 32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0};
        vt[7] = '{32'h4000_0000, 32'd2,         1'b1, 64'h0000_0000_8000_0000, 1'b1};
        vt[8] = '{32'h4000_0000, 32'd2,         1'b0, 64'h0000_0000_8000_0000, 1'b0};
        vt[9] = '{32'h8000_0000, 32'd2,         1'b0, 64'h0000_0001_0000_0000, 1'b1};
        cor[0] = 32'd0; cor[1] = 32'hFFFF_FFFF; cor[2] = 32'h8000_0000; cor[3] = 32'h7FFF_FFFF;

        start = 1'b0; is_signed = 1'b0; mcand = '0; mplier = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_done", 128'(done), 128'(0));
        chk("reset_prod", 128'(prod), 128'(0));
        chk("reset_ovf",  128'(cur_ovf()), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].sg, p, ov, lat, bc);
            chk($sformatf("vec%0d_prod", i), 128'(p), 128'(vt[i].p));
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(18));
            chk($sformatf("vec%0d_busy_cycles", i), 128'(bc), 128'(17));
`ifdef MUL_OVF_FLAG_EN
            chk($sformatf("vec%0d_ovf", i), 128'(ov), 128'(vt[i].ov));
`endif
        end

        // Clear in the middle of RUN abandons the operation
        @(negedge clk);
        mcand = 32'h1234; mplier = 32'h5678; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("clear_busy", 128'(busy), 128'(0));
        chk("clear_prod", 128'(prod), 128'(0));
        chk("clear_done", 128'(done), 128'(0));
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("no_activity_after_clear", 128'(seen), 128'(0));
        run_op(32'd12, 32'd12, 1'b0, p, ov, lat, bc);
        chk("after_clear_prod", 128'(p), 128'(144));

        // Back-to-back with start noise and operand churn during RUN
        @(negedge clk);
        mcand = 32'd7; mplier = 32'd9; is_signed = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        n = 1;
        while (!done && n < 100) begin
            start = 1'($urandom_range(0, 1));
            mcand = $urandom; mplier = $urandom; is_signed = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_first_latency", 128'(n), 128'(18));
        chk("b2b_first_prod", 128'(prod), 128'(63));
        mcand = 32'd100; mplier = 32'hFFFF_FFFE; is_signed = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(lat, bc);
        chk("b2b_second_gap", 128'(lat), 128'(18));
        chk("b2b_second_prod", 128'(prod), 128'hFFFF_FFFF_FFFF_FF38);
        @(posedge clk); #1;

        // Random 32-bit operations, biased towards corner operands
        for (int k = 0; k < 40; k++) begin
            a  = ($urandom_range(0, 3) == 0) ? cor[$urandom_range(0, 3)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? cor[$urandom_range(0, 3)] : $urandom;
            sg = 1'($urandom_range(0, 1));
            run_op(a, b, sg, p, ov, lat, bc);
            chk($sformatf("rand%0d_prod a=%0h b=%0h s=%0d", k, a, b, sg), 128'(p), 128'(ref_mul(a, b, sg)));
            chk($sformatf("rand%0d_latency", k), 128'(lat), 128'(18));
`ifdef MUL_OVF_FLAG_EN
            chk($sformatf("rand%0d_ovf", k), 128'(ov), 128'(ref_ovf(ref_mul(a, b, sg), sg)));
`endif
        end

        sweep_go = 1'b1;
        n = 0;
        while (sweep_fin < 3 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (sweep_fin < 3) begin
            n_cmp++; n_bad++;
            $display("FAIL sweep_timeout: got %0d sweeps finished, expected 3", sweep_fin);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Narrow-width instances, randomised in both modes
    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int W = 4 << g;
        logic           st, sg, bz, dn;
        logic [W-1:0]   a, b;
        logic [2*W-1:0] p;
`ifdef MUL_OVF_FLAG_EN
        logic           ov;
`endif

        booth_mul_seq #(.WIDTH(W)) u_sw (
            .clock     (clk),
            .clear     (rst),
            .start     (st),
            .is_signed (sg),
            .mcand     (a),
            .mplier    (b),
            .busy      (bz),
            .done      (dn),
            .prod      (p)
`ifdef MUL_OVF_FLAG_EN
            ,
            .ovf       (ov)
`endif
        );

        initial begin
            longint      x, y, pv;
            logic [63:0] full;
            int          n;
            st = 1'b0; sg = 1'b0; a = '0; b = '0;
            wait (sweep_go);
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                a  = W'($urandom);
                b  = W'($urandom);
                sg = 1'($urandom_range(0, 1));
                if (k < 2) begin a = '1; b = '1; sg = 1'(k); end
                if (k == 2) begin a = '0; a[W-1] = 1'b1; b = a; sg = 1'b1; end
                st = 1'b1;
                @(posedge clk); #1;
                st = 1'b0;
                n = 1;
                while (!dn && n < 100) begin
                    @(posedge clk); #1;
                    n++;
                end
                x = longint'(a);
                y = longint'(b);
                if (sg && a[W-1]) x = x - (longint'(1) << W);
                if (sg && b[W-1]) y = y - (longint'(1) << W);
                pv   = x * y;
                full = pv;
                chk($sformatf("w%0d_prod a=%0h b=%0h s=%0d", W, a, b, sg), 128'(p), 128'(full[2*W-1:0]));
                chk($sformatf("w%0d_latency", W), 128'(n), 128'(W / 2 + 2));
`ifdef MUL_OVF_FLAG_EN
                chk($sformatf("w%0d_ovf", W), 128'(ov),
                    128'(sg ? (pv < -(longint'(1) << (W - 1)) || pv >= (longint'(1) << (W - 1)))
                            : (pv >= (longint'(1) << W))));
`endif
                @(posedge clk);
            end
            sweep_fin++;
        end
    end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Sequential, parametrised radix-4 Booth multiplier. Retires one Booth digit per clock.
- Supersedes the fixed 32-bit combinational multiplier in the ALU MUL path.
- Adds a selectable signed/unsigned mode, a start/busy/done handshake, and a registered 2*WIDTH product.
- Sits beside the divider in the ALU. The control unit launches it and stalls on busy.

Parameters:
- WIDTH, 32, operand width. Must be even and at least 4.
- ITER, WIDTH/2+1, Booth iterations. Derived from WIDTH; not overridden.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- start  in  1  launch request. Sampled only in IDLE or DONE.
- is_signed  in  1  1 means two's-complement operands; 0 means unsigned. Latched at start.
- mcand  in  WIDTH  multiplicand. Latched at start.
- mplier  in  WIDTH  multiplier. Latched at start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse: product is valid.
- prod  out  2*WIDTH  product. Held until the next result is written.

Behaviour:
- Reset (clear=1, asynchronous): state=IDLE, busy=0, done=0, prod=0, all internal registers cleared. Clear mid-RUN abandons the operation; no done is produced.
- State IDLE:
  - start=1 latches the operands and the mode.
  - Multiplicand is extended to WIDTH+2 bits: sign-extended if is_signed, otherwise zero-extended.
  - Multiplier register is {ext,ext,mplier}, with ext = is_signed ? mplier[WIDTH-1] : 0.
  - Booth carry bit = 0. Accumulator (WIDTH+3 bits) = 0. Counter = 0. Next state is RUN.
- State RUN, one iteration per cycle:
  - Digit = {mplier_reg[1:0], carry}.
  - Digit mapping: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - M is sign-extended to accumulator width before the add or subtract.
  - carry <= mplier_reg[1].
  - {acc, mplier_reg} is arithmetic-shifted right by 2 after the add.
  - Counter increments. After ITER iterations, the next state is DONE.
- State DONE:
  - Lasts exactly one cycle. done=1 and busy=0.
  - prod is loaded on the edge that enters DONE, from the low 2*WIDTH bits of {acc, mplier_reg}, so prod is valid throughout the done cycle.
  - start=1 in DONE is accepted (back-to-back); otherwise the next state is IDLE.
- Latency: start sampled on edge t gives done high in the cycle after edge t+ITER (18 cycles for WIDTH=32). Throughput is one result per ITER+1 cycles.
- start while busy: ignored. The operand inputs may change freely during RUN.
- Results are exact for the full ranges, including mcand = mplier = most-negative (signed) and all-ones (unsigned).
- prod is only updated on DONE entry. It is stable in IDLE and RUN.

Optional Feature:
- Macro MUL_OVF_FLAG_EN.
- When defined, the block adds output ovf (1 bit, reset 0), registered with prod. ovf=1 when the product does not fit in WIDTH bits:
  - signed: prod[2W-1:W-1] is not all-equal;
  - unsigned: prod[2W-1:W] is non-zero.
- When undefined, there is no ovf port and no flag logic. All other behaviour is identical.

Decomposition:
- Package mul_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - Booth digit localparams (ZERO, P1, P2, M1, M2);
  - the shared width helper functions.
- One sub-module: booth_r4_select.
  - Combinational: takes the 3-bit digit and the extended multiplicand.
  - Returns the addend (0, ±M, ±2M) at accumulator width.
  - Reused later by the pipelined multiplier.

Test Plan:
1. Signed, WIDTH=32: mcand=-7 (0xFFFFFFF9), mplier=3 -> prod=0xFFFFFFFFFFFFFFEB; done exactly 18 cycles after the start edge; busy high for 17 cycles.
2. Unsigned: 0xFFFFFFFF * 0xFFFFFFFF -> prod=0xFFFFFFFE00000001. Then the same operands signed -> prod=0x0000000000000001.
3. Signed corner: 0x80000000 * 0x80000000 -> prod=0x4000000000000000. With MUL_OVF_FLAG_EN defined, ovf=1. Then 5*6 -> prod=30, ovf=0.
4. Clear pulsed at RUN iteration 8 -> busy=0, prod=0, no done pulse. A new start of 12*12 -> prod=144.
5. Back-to-back: start held high across DONE with new operands 100*-2 -> second done 18 cycles after the first; prod=0xFFFFFFFFFFFFFF38. start pulses during RUN have no effect.
6. Parameter sweep WIDTH=4, 8, 16, randomised with both modes -> prod equals the reference product; done latency = WIDTH/2+2 cycles.
